apb_acc_slave: RTL and testbench

APB3 completer front-end for the matrix accelerator. It sits between the APB bus and the convolution datapath inside acc_top. It owns the control/status registers and converts APB writes to LOAD_A and LOAD_X into valid/ready streams toward the A and X buffers. It converts APB reads of RESULT into pops from the result stream, and inserts wait states when the datapath back-pressures.

---
 rtl/apb_acc_slave_if.sv | 57 +++++
 rtl/apb_acc_slave.sv | 207 ++++++++++++++++++++
 tb/tb_apb_acc_slave.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_acc_slave_if.sv
// APB3 completer bus plus the A/X push streams and the result pop stream of the accelerator front-end.
// Pure wiring, no latency of its own.
// Backpressure is carried by a_ready/x_ready/res_valid toward the completer, and by PREADY toward the requester.
interface apb_acc_slave_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int RES_W  = 20
);
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   logic              acc_en;

   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              a_last;
   logic              a_ready;

   logic              x_valid;
   logic [DATA_W-1:0] x_data;
   logic              x_last;
   logic              x_ready;

   logic              res_valid;
   logic [RES_W-1:0]  res_data;
   logic              res_ready;

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR,
      output acc_en,
      output a_valid, a_data, a_last,
      input  a_ready,
      output x_valid, x_data, x_last,
      input  x_ready,
      input  res_valid, res_data,
      output res_ready
   );

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR,
      input  acc_en,
      input  a_valid, a_data, a_last,
      output a_ready,
      input  x_valid, x_data, x_last,
      output x_ready,
      output res_valid, res_data,
      input  res_ready
   );
endinterface

// File: rtl/apb_acc_slave.sv
// APB3 completer: CTRL/STATUS registers, LOAD_A/LOAD_X writes become stream pushes, RESULT reads pop the result stream.
// Register and error accesses complete in the first access cycle; stream accesses complete on the handshake cycle.
// A stalled stream inserts wait states up to TIMEOUT cycles, then the transfer ends with PSLVERR and no side effect.
module apb_acc_slave #(
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 32,
   parameter int RES_W   = 20,
   parameter int A_DEPTH = 18,
   parameter int X_DEPTH = 1568,
   parameter int TIMEOUT = 16
) (
   input logic              HCLK,
   input logic              HRESETn,
   apb_acc_slave_if.slave   bus
);

   localparam int A_CW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
   localparam int X_CW = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
   localparam int W_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [ADDR_W-1:0] AD_CTRL   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] AD_LOAD_A = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] AD_LOAD_X = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] AD_RESULT = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] AD_STATUS = ADDR_W'(4);

   // Registered phase only ever holds IDLE or ACCESS; the setup phase is
   // decoded from the live bus so that the access phase lines up with PENABLE.
   logic [1:0]        st;
   logic [1:0]        cur_st;

   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic              err_q;
   logic [W_CW-1:0]   wait_cnt;

   logic              acc_en_q;
   logic              a_loaded;
   logic              x_loaded;
   logic [A_CW-1:0]   a_cnt;
   logic [X_CW-1:0]   x_cnt;
   logic [7:0]        wait_err_cnt;

   logic              setup_is_load;
   logic              setup_err;
   logic              enter;
   logic              in_acc;
   logic              op_a;
   logic              op_x;
   logic              op_r;
   logic              op_reg;
   logic              hs_a;
   logic              hs_x;
   logic              hs_r;
   logic              waiting;
   logic              tmo;
   logic              done;
   logic              ctrl_wr;
   logic              rd_ctrl;
   logic              rd_status;
   logic              a_wrap;
   logic              x_wrap;
   logic [31:0]       status_w;
   logic [DATA_W-1:0] rdata;

   // Decode the bus phase: a held ACCESS wins, otherwise PSEL without PENABLE is a setup phase.
   always_comb begin
      cur_st = st;
      if (st != ST_ACCESS) begin
         cur_st = (bus.PSEL && !bus.PENABLE) ? ST_SETUP : ST_IDLE;
      end
   end

   // Error classification is fixed at access entry, using acc_en as it stands then.
   always_comb begin
      setup_is_load = (bus.PADDR == AD_LOAD_A) || (bus.PADDR == AD_LOAD_X);
      setup_err     = (bus.PADDR > AD_STATUS)
                   || (bus.PWRITE && ((bus.PADDR == AD_RESULT) || (bus.PADDR == AD_STATUS)))
                   || (!bus.PWRITE && setup_is_load)
                   || (bus.PWRITE && setup_is_load && !acc_en_q);
   end

   // Per-transfer operation decode and completion.
   always_comb begin
      in_acc    = (st == ST_ACCESS);
      op_a      = in_acc && !err_q && write_q && (addr_q == AD_LOAD_A);
      op_x      = in_acc && !err_q && write_q && (addr_q == AD_LOAD_X);
      op_r      = in_acc && !err_q && !write_q && (addr_q == AD_RESULT);
      op_reg    = in_acc && !err_q && ((addr_q == AD_CTRL) || (addr_q == AD_STATUS));
      hs_a      = op_a && bus.a_ready;
      hs_x      = op_x && bus.x_ready;
      hs_r      = op_r && bus.res_valid;
      waiting   = op_a || op_x || op_r;
      tmo       = waiting && !(hs_a || hs_x || hs_r) && (wait_cnt == W_CW'(TIMEOUT - 1));
      done      = in_acc && (err_q || op_reg || hs_a || hs_x || hs_r || tmo);
      enter     = (cur_st == ST_SETUP) || (done && bus.PSEL && !bus.PENABLE);
      ctrl_wr   = op_reg && write_q && (addr_q == AD_CTRL);
      rd_ctrl   = op_reg && !write_q && (addr_q == AD_CTRL);
      rd_status = op_reg && !write_q && (addr_q == AD_STATUS);
      a_wrap    = (a_cnt == A_CW'(A_DEPTH - 1));
      x_wrap    = (x_cnt == X_CW'(X_DEPTH - 1));
   end

   // Phase register and the address/direction/error snapshot taken at access entry.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         st      <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (enter) begin
         st      <= ST_ACCESS;
         addr_q  <= bus.PADDR;
         write_q <= bus.PWRITE;
         err_q   <= setup_err;
      end else if (done) begin
         st      <= ST_IDLE;
      end
   end

   // Wait-state counter: restarts on every access entry, advances while a stream stalls.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wait_cnt <= '0;
      end else if (enter) begin
         wait_cnt <= '0;
      end else if (waiting && !done) begin
         wait_cnt <= wait_cnt + W_CW'(1);
      end
   end

   // Control state, set counters, sticky loaded flags and the saturating wait-error count.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         acc_en_q     <= 1'b0;
         a_loaded     <= 1'b0;
         x_loaded     <= 1'b0;
         a_cnt        <= '0;
         x_cnt        <= '0;
         wait_err_cnt <= '0;
      end else begin
         if (ctrl_wr) begin
            acc_en_q <= bus.PWDATA[0];
            if (bus.PWDATA[1]) begin
               a_loaded <= 1'b0;
               x_loaded <= 1'b0;
               a_cnt    <= '0;
               x_cnt    <= '0;
            end
         end
         if (hs_a) begin
            if (a_wrap) begin
               a_cnt    <= '0;
               a_loaded <= 1'b1;
            end else begin
               a_cnt    <= a_cnt + A_CW'(1);
            end
         end
         if (hs_x) begin
            if (x_wrap) begin
               x_cnt    <= '0;
               x_loaded <= 1'b1;
            end else begin
               x_cnt    <= x_cnt + X_CW'(1);
            end
         end
         if (tmo && (wait_err_cnt != 8'hFF)) begin
            wait_err_cnt <= wait_err_cnt + 8'd1;
         end
      end
   end

   // Read data is only driven on a successful completing read; zero at all other times.
   always_comb begin
      status_w = {16'b0, wait_err_cnt, 4'b0, x_loaded, a_loaded, bus.res_valid, acc_en_q};
      rdata    = '0;
      if (rd_ctrl) begin
         rdata = DATA_W'(acc_en_q);
      end
      if (rd_status) begin
         rdata = DATA_W'(status_w);
      end
      if (hs_r) begin
         rdata = DATA_W'(bus.res_data);
      end
   end

   assign bus.PRDATA    = rdata;
   assign bus.PREADY    = done;
   assign bus.PSLVERR   = in_acc && (err_q || tmo);
   assign bus.acc_en    = acc_en_q;

   assign bus.a_valid   = op_a;
   assign bus.a_data    = op_a ? bus.PWDATA : '0;
   assign bus.a_last    = op_a && a_wrap;

   assign bus.x_valid   = op_x;
   assign bus.x_data    = op_x ? bus.PWDATA : '0;
   assign bus.x_last    = op_x && x_wrap;

   assign bus.res_ready = hs_r;

endmodule

// File: tb/tb_apb_acc_slave.sv
// Directed bench for apb_acc_slave: APB transfers with scripted stream readiness.
// A transfer-level model predicts wait states, PSLVERR, PRDATA, pushes/pops and set boundaries.
// A per-cycle monitor checks idle/reset output rules and captures stream beats.
module tb_apb_acc_slave;

   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 32;
   localparam int RES_W   = 20;
   localparam int A_DEPTH = 18;
   localparam int X_DEPTH = 1568;
   localparam int TIMEOUT = 16;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   apb_acc_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

   apb_acc_slave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W),
      .A_DEPTH(A_DEPTH), .X_DEPTH(X_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .bus(bus.slave)
   );

   int total = 0;
   int bad = 0;

   // transfer-level model
   bit         m_en, m_al, m_xl;
   int         m_an, m_xn;
   logic [7:0] m_werr;

   // monitor captures
   bit          in_access = 1'b0;
   int          n_apush, n_xpush, n_pop;
   logic [31:0] seen_a_data, seen_x_data;
   bit          seen_a_last, seen_x_last;
   logic [31:0] rd;
   bit          got_err;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_status();
      return {16'b0, m_werr, 4'b0, m_xl, m_al, 1'b0, m_en};
   endfunction

   task automatic model_reset();
      m_en = 0; m_al = 0; m_xl = 0; m_an = 0; m_xn = 0; m_werr = 8'd0;
   endtask

   task automatic drive_rdy(input logic [12:0] addr, input bit ok, input logic [19:0] rdata);
      bus.a_ready   = (addr == 13'd1) && ok;
      bus.x_ready   = (addr == 13'd2) && ok;
      bus.res_valid = (addr == 13'd3) && ok;
      bus.res_data  = rdata;
   endtask

   task automatic idle_bus();
      bus.PSEL = 0; bus.PENABLE = 0;
      bus.a_ready = 0; bus.x_ready = 0; bus.res_valid = 0; bus.res_data = '0;
      in_access = 0;
   endtask

   // One APB transfer; the stream partner becomes ready after 'delay' access cycles.
   task automatic xfer(input logic [12:0] addr, input bit wr, input logic [31:0] wdata,
                       input int delay, input logic [19:0] rdata);
      bit is_load, err, strm, tmo, exp_last_a, exp_last_x, fin;
      int exp_wait, cyc, exp_a, exp_x, exp_p;
      logic [31:0] exp_rd;
      is_load = (addr == 13'd1) || (addr == 13'd2);
      err  = (addr > 13'd4) || (wr && (addr == 13'd3 || addr == 13'd4))
          || (!wr && is_load) || (wr && is_load && !m_en);
      strm = !err && ((wr && is_load) || (!wr && addr == 13'd3));
      tmo  = strm && (delay > TIMEOUT - 1);
      exp_wait = !strm ? 0 : (tmo ? TIMEOUT - 1 : delay);
      exp_rd = 32'd0;
      if (!err && !tmo && !wr) begin
         if (addr == 13'd0) exp_rd = {31'd0, m_en};
         else if (addr == 13'd4) exp_rd = m_status();
         else if (addr == 13'd3) exp_rd = {12'd0, rdata};
      end
      exp_a = (strm && !tmo && addr == 13'd1) ? 1 : 0;
      exp_x = (strm && !tmo && addr == 13'd2) ? 1 : 0;
      exp_p = (strm && !tmo && addr == 13'd3) ? 1 : 0;
      exp_last_a = (m_an == A_DEPTH - 1);
      exp_last_x = (m_xn == X_DEPTH - 1);

      @(posedge HCLK); #1;
      bus.PSEL = 1; bus.PENABLE = 0; bus.PADDR = addr; bus.PWRITE = wr; bus.PWDATA = wdata;
      n_apush = 0; n_xpush = 0; n_pop = 0;
      @(posedge HCLK); #1;
      bus.PENABLE = 1; in_access = 1;
      cyc = 0;
      drive_rdy(addr, cyc >= delay, rdata);
      fin = 0;
      while (!fin) begin
         @(negedge HCLK);
         if (bus.PREADY) begin
            fin = 1; got_err = bus.PSLVERR; rd = bus.PRDATA;
         end else if (cyc >= 40) begin
            total++; bad++;
            $display("FAIL xfer_bound: no PREADY after %0d cycles, want at most %0d", cyc, TIMEOUT - 1);
            fin = 1; got_err = 0; rd = 32'hxxxxxxxx;
         end else begin
            cyc++;
            @(posedge HCLK); #1;
            drive_rdy(addr, cyc >= delay, rdata);
         end
      end
      @(posedge HCLK); #1;
      idle_bus();

      chk("wait_states", 32'(cyc), 32'(exp_wait));
      chk("pslverr", {31'd0, got_err}, {31'd0, err || tmo});
      chk("prdata", rd, exp_rd);
      chk("a_pushes", 32'(n_apush), 32'(exp_a));
      chk("x_pushes", 32'(n_xpush), 32'(exp_x));
      chk("res_pops", 32'(n_pop), 32'(exp_p));
      if (exp_a == 1) begin
         chk("a_data", seen_a_data, wdata);
         chk("a_last", {31'd0, seen_a_last}, {31'd0, exp_last_a});
      end
      if (exp_x == 1) begin
         chk("x_data", seen_x_data, wdata);
         chk("x_last", {31'd0, seen_x_last}, {31'd0, exp_last_x});
      end

      if (wr && addr == 13'd0 && !err) begin
         m_en = wdata[0];
         if (wdata[1]) begin m_an = 0; m_xn = 0; m_al = 0; m_xl = 0; end
      end
      if (exp_a == 1) begin
         if (m_an == A_DEPTH - 1) begin m_an = 0; m_al = 1; end else m_an++;
      end
      if (exp_x == 1) begin
         if (m_xn == X_DEPTH - 1) begin m_xn = 0; m_xl = 1; end else m_xn++;
      end
      if (tmo && m_werr != 8'hFF) m_werr = m_werr + 8'd1;
   endtask

   // Per-cycle compare: reset/idle output rules, stream beat capture.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         chk("reset_outputs",
             {24'd0, bus.PREADY, bus.PSLVERR, bus.acc_en, bus.a_valid, bus.x_valid,
              bus.res_ready, bus.a_last, bus.x_last}, 32'd0);
         chk("reset_prdata", bus.PRDATA, 32'd0);
      end else begin
         if (!bus.PREADY) chk("prdata_not_ready", bus.PRDATA, 32'd0);
         if (!in_access) chk("streams_idle", {29'd0, bus.a_valid, bus.x_valid, bus.res_ready}, 32'd0);
         if (bus.a_valid) chk("a_data_live", bus.a_data, bus.PWDATA);
         if (bus.x_valid) chk("x_data_live", bus.x_data, bus.PWDATA);
         if (bus.a_valid && bus.a_ready) begin
            n_apush++; seen_a_data = bus.a_data; seen_a_last = bus.a_last;
         end
         if (bus.x_valid && bus.x_ready) begin
            n_xpush++; seen_x_data = bus.x_data; seen_x_last = bus.x_last;
         end
         if (bus.res_ready) begin
            n_pop++;
            chk("pop_needs_valid", {31'd0, bus.res_valid}, 32'd1);
         end
      end
   end

   initial begin
      bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 0;
      idle_bus();
      model_reset();
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1;

      // 1: register access after reset
      xfer(13'd0, 1, 32'h1, 0, 20'd0);
      xfer(13'd0, 0, 32'h0, 0, 20'd0);
      chk("lit_ctrl_rd", rd, 32'h1);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_rd", rd, 32'h1);

      // 2: one full A set with a_ready always high
      for (int i = 0; i < A_DEPTH; i++) xfer(13'd1, 1, 32'h100 + 32'(i), 0, 20'd0);
      chk("lit_a_last_w18", {31'd0, seen_a_last}, 32'd1);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_a_loaded", rd, 32'h5);

      // 3: X write stalled five cycles, then ready exactly at the timeout cycle
      xfer(13'd2, 1, 32'hA5, 5, 20'd0);
      chk("lit_x_data", seen_x_data, 32'hA5);
      xfer(13'd2, 1, 32'h5A, TIMEOUT - 1, 20'd0);

      // 4: RESULT timeout, then good reads
      xfer(13'd3, 0, 32'h0, 99, 20'd0);
      chk("lit_tmo_err", {31'd0, got_err}, 32'd1);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_werr", rd, 32'h105);
      xfer(13'd3, 0, 32'h0, 0, 20'h3FFFF);
      chk("lit_result", rd, 32'h0003FFFF);
      xfer(13'd3, 0, 32'h0, TIMEOUT - 1, 20'h12345);

      // 5: error transfers leave state alone
      xfer(13'd7, 1, 32'hFFFF_FFFF, 0, 20'd0);
      xfer(13'd1, 0, 32'h0, 0, 20'd0);
      xfer(13'd3, 1, 32'h3, 0, 20'd0);
      xfer(13'd4, 1, 32'h3, 0, 20'd0);
      xfer(13'd0, 1, 32'h0, 0, 20'd0);
      xfer(13'd1, 1, 32'hDEAD, 0, 20'd0);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_after_err", rd, 32'h104);
      xfer(13'd0, 1, 32'h1, 0, 20'd0);

      // 6: reset in the middle of a stalled LOAD_X
      @(posedge HCLK); #1;
      bus.PSEL = 1; bus.PENABLE = 0; bus.PADDR = 13'd2; bus.PWRITE = 1; bus.PWDATA = 32'h77;
      n_xpush = 0;
      @(posedge HCLK); #1;
      bus.PENABLE = 1; in_access = 1;
      repeat (3) @(posedge HCLK);
      #2 HRESETn = 0;
      #1 chk("rst_x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("rst_pready", {31'd0, bus.PREADY}, 32'd0);
      @(posedge HCLK); #1;
      idle_bus();
      @(posedge HCLK); #1;
      HRESETn = 1;
      chk("rst_no_push", 32'(n_xpush), 32'd0);
      model_reset();
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_after_rst", rd, 32'h0);

      // partial A load, clear, then a full set must end on word 18
      xfer(13'd0, 1, 32'h1, 0, 20'd0);
      for (int i = 0; i < 7; i++) xfer(13'd1, 1, 32'h200 + 32'(i), 0, 20'd0);
      xfer(13'd0, 1, 32'h2, 0, 20'd0);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_cleared", rd, 32'h0);
      xfer(13'd0, 1, 32'h1, 0, 20'd0);
      for (int i = 0; i < A_DEPTH; i++) begin
         xfer(13'd1, 1, 32'h300 + 32'(i), 0, 20'd0);
         if (i == 6) chk("lit_a_last_w7", {31'd0, seen_a_last}, 32'd0);
      end
      chk("lit_a_last_set2", {31'd0, seen_a_last}, 32'd1);

      // full X set from a reset counter
      for (int i = 0; i < X_DEPTH; i++) xfer(13'd2, 1, 32'(i), (i % 97 == 0) ? 2 : 0, 20'd0);
      chk("lit_x_last_w1568", {31'd0, seen_x_last}, 32'd1);
      xfer(13'd4, 0, 32'h0, 0, 20'd0);
      chk("lit_status_both_loaded", rd, 32'hD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
